bt_tx_arbiter: RTL and testbench
================================

Name: bt_tx_arbiter

Overview:
- Shares the single UART transmitter of the Bluetooth link between up to NUM_REQ byte producers, e.g. the command responder, periodic telemetry streamer and debug dump.
- Round-robin grant per packet; a granted requester holds the link until its last byte or a timeout.
- Drives the uart transmit pulse and tx_byte, and paces bytes off is_transmitting.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 1024, idle cycles allowed inside a locked packet before forced release.
- SETTLE_CYC, 2, cycles after the transmit pulse during which is_transmitting is ignored (covers uart busy-flag latency).

Ports:
- clk  in  1  master clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte on its lane.
- req_byte  in  NUM_REQ*8  byte lanes; lane i is bits [8i+7:8i].
- req_last  in  NUM_REQ  byte on lane i ends its packet.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- transmit  out  1  one-cycle pulse to uart.
- tx_byte  out  8  byte to uart.
- is_transmitting  in  1  uart busy flag.
- grant_id  out  clog2(NUM_REQ)  current or last granted requester.
- grant_active  out  1  a packet is in progress (state is not IDLE).
- timeout_err  out  1  one-cycle pulse on forced release.
- sent_count  out  16  total bytes issued; wraps.

Behaviour:
- Reset (async assert, sync deassert in the design's reset tree): state=IDLE, and rr_ptr, grant_id, tx_byte, sent_count, req_ready, transmit, timeout_err, grant_active and all counters are 0.
- Reset mid-packet aborts immediately. No transmit is issued after reset; the uart finishes any byte already started.
- Handshake: byte i is transferred in the cycle req_valid[i]&&req_ready[i]. A requester holds valid, byte and last stable until ready. req_ready is combinational from state plus registered grant, never more than one bit high, and never high outside IDLE/HOLD.
- States: IDLE, ISSUE, SETTLE, WAIT_DONE, HOLD.
- IDLE:
  - if any req_valid and !is_transmitting: pick the first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Assert its req_ready; latch byte into tx_byte, last into last_q, index into grant_id; go to ISSUE.
  - Otherwise stay.
- ISSUE: transmit=1 for exactly this cycle; sent_count+=1 (0xFFFF->0x0000); load settle counter; go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to WAIT_DONE. With SETTLE_CYC=0, go to WAIT_DONE directly.
- WAIT_DONE:
  - wait for is_transmitting==0.
  - If last_q: rr_ptr=grant_id+1 mod NUM_REQ, go to IDLE.
  - Else: clear timeout counter, go to HOLD.
- HOLD:
  - only lane grant_id is eligible; other lanes see ready=0 regardless of valid.
  - If req_valid[grant_id]: accept as in IDLE, go to ISSUE.
  - Else increment timeout counter. When it reaches TIMEOUT_CYC-1 with no valid: timeout_err=1 for that cycle, rr_ptr=grant_id+1, go to IDLE.
  - A valid arriving in that same cycle wins; no timeout is flagged.
- Latency: accept at cycle N -> transmit at N+1. tx_byte changes only on accept and stays stable through the uart load.
- Minimum spacing between transmit pulses is 1+SETTLE_CYC+uart frame time.
- A requester dropping valid before being granted is legal; arbitration is re-evaluated every IDLE cycle.
- grant_id holds its last value in IDLE.

Test Plan:
- Single-byte packet: is_transmitting=0, lane0 valid byte 0x5A last=1. Required: ready[0] at N; transmit at N+1 with tx_byte=0x5A; sent_count=1. After the uart busy period: IDLE, rr_ptr=1.
- Fairness: lanes 0 and 2 both valid, single-byte, held continuously. Required: grant order 0,2,0,2; no lane is granted twice in a row while the other waits.
- Packet lock: lane1 sends 0x01,0x02,0x03 with last on 0x03 while lane0 stays valid. Required: three lane1 bytes transmitted back-to-back, ready[0]=0 throughout, then lane0 granted.
- Busy gating: is_transmitting=1 at request time, released 50 cycles later. Required: no ready or transmit until the cycle after release.
- Timeout: TIMEOUT_CYC=16; lane3 sends one byte last=0, then drops valid. Required: timeout_err pulse 15 cycles after HOLD entry; IDLE; rr_ptr=0; next grant may go to any lane.
- Reset mid-packet: assert rst_n=0 in HOLD after 2 bytes. Required: all outputs 0 asynchronously. After release, a fresh lane0 request is served with sent_count restarting at 1.

Source files
------------

// File: rtl/bt_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Bytes are paced off the UART busy flag, with a settle window after each transmit pulse.
module bt_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned SETTLE_CYC  = 2,
    localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    input  logic                 is_transmitting,
    output logic [ID_W-1:0]      grant_id,
    output logic                 grant_active,
    output logic                 timeout_err,
    output logic [15:0]          sent_count
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic              last_q;
    logic              armed_q;
    logic              accept;
    logic [ID_W-1:0]   acc_idx;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   cand;
    logic              pick_found;
    logic [ID_W-1:0]   grant_next;
    logic [7:0]        lane_byte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane_byte[g] = req_byte[8*g +: 8];
    end

    assign grant_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // First valid lane searching upward from the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state, handshake and timeout decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        req_ready   = '0;
        timeout_err = 1'b0;
        accept      = 1'b0;
        acc_idx     = grant_id;

        unique case (state_q)
            IDLE: begin
                if (armed_q && pick_found && !is_transmitting) begin
                    accept  = 1'b1;
                    acc_idx = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (SETTLE_CYC == 0) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!is_transmitting) begin
                    if (last_q) begin
                        rr_d    = grant_next;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (armed_q && req_valid[grant_id]) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_err = 1'b1;
                    rr_d        = grant_next;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            req_ready[acc_idx] = 1'b1;
        end
    end

    // Control state; armed_q keeps ready low through reset and its first released cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            armed_q <= 1'b1;
        end
    end

    // Byte latch, transmit pulse and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte      <= '0;
            last_q       <= 1'b0;
            grant_id     <= '0;
            transmit     <= 1'b0;
            sent_count   <= '0;
            grant_active <= 1'b0;
        end else begin
            transmit     <= accept;
            grant_active <= (state_d != IDLE);
            if (accept) begin
                tx_byte  <= lane_byte[acc_idx];
                last_q   <= req_last[acc_idx];
                grant_id <= acc_idx;
            end
            if (state_q == ISSUE) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bt_tx_arbiter.sv
// Directed bench for bt_tx_arbiter: a simple UART busy model, an edge monitor that logs
// accepts/transmits/timeouts, and one task per scenario with hand-computed expectations.
module tb_bt_tx_arbiter;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned SETTLE_CYC  = 2;
    localparam int          FRAME       = 10;
    // transmit at T, busy T+1..T+10, HOLD entered at T+12, timeout decided at T+12+15
    localparam int          TO_DELAY    = 27;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_byte = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 transmit;
    logic [7:0]           tx_byte;
    logic                 is_transmitting;
    logic [1:0]           grant_id;
    logic                 grant_active;
    logic                 timeout_err;
    logic [15:0]          sent_count;

    int errors = 0;
    int checks = 0;

    bt_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_byte       (req_byte),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .transmit       (transmit),
        .tx_byte        (tx_byte),
        .is_transmitting(is_transmitting),
        .grant_id       (grant_id),
        .grant_active   (grant_active),
        .timeout_err    (timeout_err),
        .sent_count     (sent_count)
    );

    always #5 clk = ~clk;

    // UART busy model: busy for FRAME cycles starting the cycle after the pulse.
    int   busy_cnt = 0;
    logic force_busy = 1'b0;
    always @(posedge clk) begin
        if (transmit) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign is_transmitting = force_busy || (busy_cnt != 0);

    // Edge monitor: values seen here are those settled before the edge.
    int         cyc = 0;
    int         acc_log[$];
    logic [7:0] tx_log[$];
    int         tx_cyc = 0;
    int         to_cyc = 0;
    int         to_count = 0;
    int         tx_count = 0;
    int         ready_count = 0;
    int         onehot_viol = 0;
    int         lock_viol = 0;
    bit         lock_watch = 1'b0;
    always @(posedge clk) begin
        if ($countones(req_ready) > 1) onehot_viol++;
        if (req_ready != '0) ready_count++;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_ready[i]) acc_log.push_back(i);
        if (transmit) begin
            tx_log.push_back(tx_byte);
            tx_cyc = cyc;
            tx_count++;
        end
        if (timeout_err) begin
            to_count++;
            to_cyc = cyc;
        end
        if (lock_watch && req_ready[0]) lock_viol++;
        cyc++;
    end

    task automatic set_lane(input int i, input logic v, input logic [7:0] b, input logic l);
        req_valid[i]       = v;
        req_byte[8*i +: 8] = b;
        req_last[i]        = l;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        tx_log.delete();
    endtask

    task automatic wait_acc(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (acc_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!grant_active && !is_transmitting) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit got=%b exp=0", transmit); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL reset_grant_active got=%b exp=0", grant_active); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
        checks++; if (sent_count !== 16'd0) begin errors++; $display("FAIL reset_sent_count got=%0d exp=0", sent_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        bit ok;
        clear_logs();
        set_lane(0, 1'b1, 8'h5A, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        @(negedge clk);
        checks++; if (transmit !== 1'b1) begin errors++; $display("FAIL single_transmit got=%b exp=1", transmit); end
        checks++; if (tx_byte !== 8'h5A) begin errors++; $display("FAIL single_tx_byte got=%h exp=5a", tx_byte); end
        checks++; if (grant_active !== 1'b1) begin errors++; $display("FAIL single_grant_active got=%b exp=1", grant_active); end
        set_lane(0, 1'b0, 8'h00, 1'b0);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_idle got=busy exp=idle"); end
        checks++; if (sent_count !== 16'd1) begin errors++; $display("FAIL single_sent_count got=%0d exp=1", sent_count); end
        // Pointer moved past lane 0: with every lane valid, lane 1 wins.
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1'b1, 8'(8'h40 + i), 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rr_after_single got=%b exp=0010", req_ready); end
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1'b0, 8'h00, 1'b0);
        wait_idle(ok);
    endtask

    task automatic test_fairness();
        bit ok;
        int exp_lane[4] = '{2, 0, 2, 0};
        clear_logs();
        set_lane(0, 1'b1, 8'hA0, 1'b1);
        set_lane(2, 1'b1, 8'hA2, 1'b1);
        wait_acc(4, ok);
        set_lane(0, 1'b0, 8'h00, 1'b0);
        set_lane(2, 1'b0, 8'h00, 1'b0);
        checks++; if (!ok) begin errors++; $display("FAIL fair_accepts got=%0d exp=4", acc_log.size()); end
        wait_idle(ok);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (acc_log.size() <= k || acc_log[k] != exp_lane[k]) begin
                errors++; $display("FAIL fair_order[%0d] got=%0d exp=%0d", k, (acc_log.size() > k) ? acc_log[k] : -1, exp_lane[k]);
            end
            checks++;
            if (tx_log.size() <= k || tx_log[k] !== ((exp_lane[k] == 0) ? 8'hA0 : 8'hA2)) begin
                errors++; $display("FAIL fair_byte[%0d] got=%h exp=%h", k, (tx_log.size() > k) ? tx_log[k] : 8'hxx, (exp_lane[k] == 0) ? 8'hA0 : 8'hA2);
            end
        end
    endtask

    task automatic test_packet_lock();
        bit ok;
        bit all_ok = 1'b1;
        logic [7:0] lb[3] = '{8'h01, 8'h02, 8'h03};
        int exp_lane[4] = '{1, 1, 1, 0};
        logic [7:0] exp_byte[4] = '{8'h01, 8'h02, 8'h03, 8'hB0};
        clear_logs();
        lock_viol  = 0;
        lock_watch = 1'b1;
        set_lane(0, 1'b1, 8'hB0, 1'b1);
        for (int b = 0; b < 3; b++) begin
            set_lane(1, 1'b1, lb[b], (b == 2));
            wait_acc(b + 1, ok);
            all_ok &= ok;
        end
        set_lane(1, 1'b0, 8'h00, 1'b0);
        lock_watch = 1'b0;
        wait_acc(4, ok);
        all_ok &= ok;
        set_lane(0, 1'b0, 8'h00, 1'b0);
        wait_idle(ok);
        checks++; if (!all_ok) begin errors++; $display("FAIL lock_progress got=%0d accepts exp=4", acc_log.size()); end
        checks++; if (lock_viol != 0) begin errors++; $display("FAIL lock_ready0 got=%0d cycles exp=0", lock_viol); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (acc_log.size() <= k || acc_log[k] != exp_lane[k] || tx_log.size() <= k || tx_log[k] !== exp_byte[k]) begin
                errors++; $display("FAIL lock_seq[%0d] got lane=%0d byte=%h exp lane=%0d byte=%h", k,
                    (acc_log.size() > k) ? acc_log[k] : -1, (tx_log.size() > k) ? tx_log[k] : 8'hxx, exp_lane[k], exp_byte[k]);
            end
        end
    endtask

    task automatic test_busy_gating();
        bit ok;
        int r0;
        int t0;
        clear_logs();
        force_busy = 1'b1;
        set_lane(2, 1'b1, 8'hC2, 1'b1);
        r0 = ready_count;
        t0 = tx_count;
        repeat (50) @(negedge clk);
        checks++; if (ready_count != r0) begin errors++; $display("FAIL busy_ready got=%0d exp=%0d", ready_count, r0); end
        checks++; if (tx_count != t0) begin errors++; $display("FAIL busy_transmit got=%0d exp=%0d", tx_count, t0); end
        force_busy = 1'b0;
        @(negedge clk);
        checks++; if (transmit !== 1'b1 || tx_byte !== 8'hC2) begin errors++; $display("FAIL busy_release got transmit=%b byte=%h exp transmit=1 byte=c2", transmit, tx_byte); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL busy_grant got=%0d exp=2", grant_id); end
        set_lane(2, 1'b0, 8'h00, 1'b0);
        wait_idle(ok);
    endtask

    task automatic test_timeout();
        bit ok;
        int t;
        clear_logs();
        t = to_count;
        set_lane(3, 1'b1, 8'hD3, 1'b0);
        wait_acc(1, ok);
        set_lane(3, 1'b0, 8'h00, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (to_count > t) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL timeout_seen got=none exp=pulse"); end
        checks++; if (to_cyc - tx_cyc != TO_DELAY) begin errors++; $display("FAIL timeout_delay got=%0d exp=%0d", to_cyc - tx_cyc, TO_DELAY); end
        checks++; if (timeout_err !== 1'b0 || grant_active !== 1'b0) begin errors++; $display("FAIL timeout_after got err=%b active=%b exp 0 0", timeout_err, grant_active); end
        checks++; if (to_count != t + 1) begin errors++; $display("FAIL timeout_pulses got=%0d exp=1", to_count - t); end
        // Pointer advanced past lane 3, so lane 0 beats lane 3.
        set_lane(3, 1'b1, 8'hD4, 1'b1);
        set_lane(0, 1'b1, 8'hD0, 1'b1);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL timeout_rr got=%b exp=0001", req_ready); end
        @(negedge clk);
        set_lane(3, 1'b0, 8'h00, 1'b0);
        set_lane(0, 1'b0, 8'h00, 1'b0);
        wait_idle(ok);
    endtask

    task automatic test_timeout_race();
        bit ok;
        int t;
        clear_logs();
        t = to_count;
        set_lane(3, 1'b1, 8'hE0, 1'b0);
        wait_acc(1, ok);
        set_lane(3, 1'b0, 8'h00, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_log.size() == 1 && cyc == tx_cyc + TO_DELAY) begin
                ok = 1'b1;
                break;
            end
        end
        set_lane(3, 1'b1, 8'hE1, 1'b1);
        wait_acc(2, ok);
        set_lane(3, 1'b0, 8'h00, 1'b0);
        wait_idle(ok);
        checks++; if (to_count != t) begin errors++; $display("FAIL race_no_timeout got=%0d pulses exp=0", to_count - t); end
        checks++; if (tx_log.size() != 2 || tx_log[1] !== 8'hE1) begin errors++; $display("FAIL race_byte got=%0d bytes last=%h exp=2 last=e1", tx_log.size(), (tx_log.size() > 0) ? tx_log[tx_log.size()-1] : 8'hxx); end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        clear_logs();
        set_lane(1, 1'b1, 8'h11, 1'b0);
        wait_acc(1, ok);
        set_lane(1, 1'b1, 8'h12, 1'b0);
        wait_acc(2, ok);
        set_lane(1, 1'b0, 8'h00, 1'b0);
        repeat (14) @(negedge clk);
        checks++; if (grant_active !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL mid_hold got active=%b id=%0d exp 1 1", grant_active, grant_id); end
        set_lane(0, 1'b1, 8'h77, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (transmit !== 1'b0 || req_ready !== 4'b0000 || timeout_err !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got tx=%b ready=%b to=%b exp 0", transmit, req_ready, timeout_err); end
        checks++; if (grant_id !== 2'd0 || grant_active !== 1'b0) begin errors++; $display("FAIL mid_rst_grant got id=%0d active=%b exp 0 0", grant_id, grant_active); end
        checks++; if (tx_byte !== 8'h00 || sent_count !== 16'd0) begin errors++; $display("FAIL mid_rst_data got byte=%h count=%0d exp 00 0", tx_byte, sent_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_acc(3, ok);
        checks++; if (!ok || transmit !== 1'b1 || tx_byte !== 8'h77 || grant_id !== 2'd0) begin errors++; $display("FAIL mid_fresh got tx=%b byte=%h id=%0d exp 1 77 0", transmit, tx_byte, grant_id); end
        set_lane(0, 1'b0, 8'h00, 1'b0);
        wait_idle(ok);
        checks++; if (sent_count !== 16'd1) begin errors++; $display("FAIL mid_sent_count got=%0d exp=1", sent_count); end
    endtask

    task automatic test_onehot();
        checks++; if (onehot_viol != 0) begin errors++; $display("FAIL ready_onehot got=%0d cycles exp=0", onehot_viol); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fairness();
        test_packet_lock();
        test_busy_gating();
        test_timeout();
        test_timeout_race();
        test_reset_mid_packet();
        test_onehot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
